cache_req_arbiter: RTL and testbench
====================================

// Module: cache_req_arbiter
// PURPOSE
//  Round-robin arbiter sharing one cache controller lookup engine between N_REQ requesters.
//  Accepts one request at a time, issues it to the engine as a start pulse plus rw/address,
//  waits for the engine's done, then returns hit/miss to the granted requester.
//  Watchdog aborts a hung lookup. Sits between the trace/CPU request ports and the controller.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  ADDR_W   32   physical address width (matches controller n_pa_bits)
//  TIMEOUT  255  max WAIT cycles before abort (1..255; 8-bit watchdog counter)
//  ID_W     2    grant id width, = clog2(N_REQ)
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-low
//  req_valid  in   N_REQ         per-requester request pending; held until req_ready seen
//  req_rw     in   N_REQ         per-requester 1=write, 0=read
//  req_addr   in   N_REQ*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
//  req_ready  out  N_REQ         one-hot, 1-cycle accept pulse
//  rsp_valid  out  N_REQ         one-hot, 1-cycle completion pulse
//  rsp_hit    out  1             hit flag, valid while rsp_valid!=0
//  rsp_err    out  1             timeout flag, valid while rsp_valid!=0
//  cc_start   out  1             1-cycle start pulse to the lookup engine
//  cc_rw      out  1             rw of issued request, held ISSUE..RESP
//  cc_addr    out  ADDR_W        address of issued request, held ISSUE..RESP
//  cc_done    in   1             engine completion pulse
//  cc_hit     in   1             engine hit flag, qualified by cc_done
//  busy       out  1             1 in any state except IDLE
//  grant_id   out  ID_W          index of current/last granted requester
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE; all outputs 0; last_grant=N_REQ-1 so
//   requester 0 has top priority first; watchdog=0. Applies in any state; in-flight txn dropped,
//   no rsp_valid issued, engine result arriving later ignored (IDLE ignores cc_done).
//  FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
//  IDLE: if |req_valid, pick first i with req_valid[i] scanning last_grant+1, +2 .. wrapping mod
//   N_REQ; latch req_rw[i], req_addr[i], grant_id=i; -> ISSUE. Else stay.
//  ISSUE (1 cycle): req_ready[grant_id]=1, cc_start=1; watchdog=0; -> WAIT.
//  WAIT: cc_done sampled only here. cc_done=1 -> latch rsp_hit=cc_hit, rsp_err=0, -> RESP.
//   Else watchdog+1; when watchdog reaches TIMEOUT-1 with no done -> rsp_hit=0, rsp_err=1, -> RESP.
//   cc_done and timeout in same cycle: done wins (rsp_err=0).
//  RESP (1 cycle): rsp_valid[grant_id]=1; last_grant=grant_id; -> IDLE.
//  Min latency req accepted-to-rsp: IDLE->ISSUE->WAIT(>=1)->RESP = 4 cycles at 1-cycle engine.
//  Throughput: at most one txn per 4 cycles; no pipelining, no queuing.
//  Requester dropping req_valid before its req_ready: not granted, no error. Requester holding
//   req_valid after req_ready: treated as a new request, eligible next IDLE.
//  cc_done outside WAIT: ignored. req_* changes after grant: ignored (latched copy used).
//  Fairness: with all N_REQ valid continuously, grants cycle 0,1,..,N_REQ-1,0,..
//  rsp_hit/rsp_err/cc_rw/cc_addr hold value until next update; rsp_* meaningful only with rsp_valid.
// TESTING
//  1 Reset then req_valid=4'b0001, addr=0x0000_1230 rw=0, engine done+hit after 1 cycle ->
//    req_ready=0001 at cycle 2, cc_start at cycle 2 with cc_addr=0x0000_1230, rsp_valid=0001 rsp_hit=1.
//  2 req_valid=4'b1111 held, engine 1-cycle done -> grant order 0,1,2,3,0; each rsp_valid one-hot.
//  3 Only req 2 valid after grant to 3 -> wrap scan 0,1,2 grants 2; then req 0 and 3 valid -> 3 is
//    skipped? no: last=2, scan 3 first -> grant 3, then 0.
//  4 Engine never asserts cc_done, TIMEOUT=255 -> rsp_valid after 255 WAIT cycles, rsp_err=1,
//    rsp_hit=0; cc_done+timeout same cycle -> rsp_err=0.
//  5 reset=0 during WAIT, later cc_done=1 in IDLE -> no rsp_valid; next req from req 0 granted first.
//  6 Write req rw=1 addr=0xFFFF_FFF0, miss -> cc_rw=1 held ISSUE..RESP, rsp_hit=0, rsp_err=0.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
// Round-robin arbiter that shares one cache lookup engine between N_REQ
// requesters. One transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT (1..TIMEOUT cycles) -> RESP -> IDLE
// A watchdog aborts a lookup whose engine never signals done.
//
// Handshake semantics:
//   Request side: a requester raises req_valid_i[i] with req_rw_i[i] and its
//   address slice, and holds them until it sees req_ready_o[i] for one cycle.
//   The request is accepted in that cycle. Dropping valid before ready simply
//   withdraws the request. Holding valid after ready posts a new request.
//   The rw/address are latched at grant, so later changes are ignored.
//   Engine side: cc_start_o is a one-cycle pulse with cc_rw_o/cc_addr_o held
//   from ISSUE until RESP. cc_done_i (with cc_hit_i) is only looked at in WAIT.
//   Response side: rsp_valid_o is a one-hot single-cycle pulse, and
//   rsp_hit_o/rsp_err_o are meaningful only while it is non-zero.
// The current FSM state is exposed on state_o for observation.

module cache_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,      // synchronous, active-low
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_rw_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic                    rsp_hit_o,
    output logic                    rsp_err_o,
    output logic                    cc_start_o,
    output logic                    cc_rw_o,
    output logic [ADDR_W-1:0]       cc_addr_o,
    input  logic                    cc_done_i,
    input  logic                    cc_hit_i,
    output logic                    busy_o,
    output logic [ID_W-1:0]         grant_id_o,
    output logic [1:0]              state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Last watchdog value at which WAIT is still allowed to see done.
    localparam logic [7:0]      WD_LAST  = 8'(TIMEOUT - 1);
    // Reset value of last_grant so that requester 0 is scanned first.
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

    logic [1:0]        state_q,      state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   grant_id_q,   grant_id_d;
    logic              cc_rw_q,      cc_rw_d;
    logic [ADDR_W-1:0] cc_addr_q,    cc_addr_d;
    logic              cc_start_q,   cc_start_d;
    logic [7:0]        wd_q,         wd_d;
    logic              rsp_hit_q,    rsp_hit_d;
    logic              rsp_err_q,    rsp_err_d;
    logic [N_REQ-1:0]  req_ready_q,  req_ready_d;
    logic [N_REQ-1:0]  rsp_valid_q,  rsp_valid_d;
    logic              busy_q,       busy_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   scan_id;
    logic [ADDR_W-1:0] pick_addr;

    // Round-robin pick: first valid requester after last_grant, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_id = ID_W'((int'(last_grant_q) + k) % N_REQ);
            if (!pick_found && req_valid_i[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
        pick_addr = req_addr_i[int'(pick_id)*ADDR_W +: ADDR_W];
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        cc_rw_d      = cc_rw_q;
        cc_addr_d    = cc_addr_q;
        wd_d         = wd_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_err_d    = rsp_err_q;
        cc_start_d   = 1'b0;
        req_ready_d  = '0;
        rsp_valid_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d              = S_ISSUE;
                    grant_id_d           = pick_id;
                    cc_rw_d              = req_rw_i[pick_id];
                    cc_addr_d            = pick_addr;
                    req_ready_d[pick_id] = 1'b1;
                    cc_start_d           = 1'b1;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a timeout in the same cycle
                if (cc_done_i) begin
                    rsp_hit_d               = cc_hit_i;
                    rsp_err_d               = 1'b0;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    state_d                 = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    rsp_hit_d               = 1'b0;
                    rsp_err_d               = 1'b1;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    state_d                 = S_RESP;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            S_RESP: begin
                last_grant_d = grant_id_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_RST;
            grant_id_q   <= '0;
            cc_rw_q      <= 1'b0;
            cc_addr_q    <= '0;
            cc_start_q   <= 1'b0;
            wd_q         <= '0;
            rsp_hit_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            cc_rw_q      <= cc_rw_d;
            cc_addr_q    <= cc_addr_d;
            cc_start_q   <= cc_start_d;
            wd_q         <= wd_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_err_q    <= rsp_err_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_err_o   = rsp_err_q;
    assign cc_start_o  = cc_start_q;
    assign cc_rw_o     = cc_rw_q;
    assign cc_addr_o   = cc_addr_q;
    assign busy_o      = busy_q;
    assign grant_id_o  = grant_id_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter (N_REQ=4, ADDR_W=32, TIMEOUT=255).
// Inputs change 1 time unit after the rising edge and outputs are sampled at
// that same point, so each tick() lands inside the next FSM cycle.

module tb_cache_req_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_rw;
    logic [127:0] req_addr;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic         rsp_hit;
    logic         rsp_err;
    logic         cc_start;
    logic         cc_rw;
    logic [31:0]  cc_addr;
    logic         cc_done;
    logic         cc_hit;
    logic         busy;
    logic [1:0]   grant_id;
    logic [1:0]   state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] a_tb [4];
    logic        rw_tb [4];

    cache_req_arbiter #(
        .N_REQ  (4),
        .ADDR_W (32),
        .TIMEOUT(255),
        .ID_W   (2)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_n),
        .req_valid_i(req_valid),
        .req_rw_i   (req_rw),
        .req_addr_i (req_addr),
        .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid),
        .rsp_hit_o  (rsp_hit),
        .rsp_err_o  (rsp_err),
        .cc_start_o (cc_start),
        .cc_rw_o    (cc_rw),
        .cc_addr_o  (cc_addr),
        .cc_done_i  (cc_done),
        .cc_hit_i   (cc_hit),
        .busy_o     (busy),
        .grant_id_o (grant_id),
        .state_o    (state)
    );

    // clock / global time limit
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL time_limit: got no finish expected finish before 500000");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_reqs();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32] = a_tb[i];
            req_rw[i]            = rw_tb[i];
        end
    endtask

    // Called in an IDLE cycle with req_valid already set. Runs one transaction
    // that spends wait_cycles cycles in WAIT; done is raised in the last one.
    task automatic do_txn(input string tag, input int g, input logic [31:0] exp_addr,
                          input logic exp_rw, input logic hit, input int wait_cycles,
                          input bit scramble);
        logic [3:0] exp_oh;
        exp_oh = 4'(1 << g);
        tick();                                   // ISSUE
        check_eq({tag, ".ready"}, req_ready, exp_oh);
        check_eq({tag, ".issue"}, {cc_start, busy, state, grant_id, cc_rw, cc_addr},
                 {1'b1, 1'b1, 2'd1, 2'(g), exp_rw, exp_addr});
        if (scramble) begin
            req_addr = ~req_addr;
            req_rw   = ~req_rw;
        end
        for (int c = 0; c < wait_cycles; c++) begin
            tick();                               // WAIT
            check_eq({tag, ".wait"}, {rsp_valid, req_ready, cc_start, state, cc_rw, cc_addr},
                     {4'b0, 4'b0, 1'b0, 2'd2, exp_rw, exp_addr});
            if (c == wait_cycles - 1) begin
                cc_done = 1'b1;
                cc_hit  = hit;
            end
        end
        tick();                                   // RESP
        cc_done = 1'b0;
        cc_hit  = 1'b0;
        check_eq({tag, ".rsp_valid"}, rsp_valid, exp_oh);
        check_eq({tag, ".rsp"}, {rsp_hit, rsp_err, busy, state, cc_rw, cc_addr},
                 {hit, 1'b0, 1'b1, 2'd3, exp_rw, exp_addr});
        tick();                                   // IDLE
        check_eq({tag, ".idle"}, {rsp_valid, busy, state}, {4'b0, 1'b0, 2'd0});
    endtask

    int t2_order [5] = '{0, 1, 2, 3, 0};
    int bad;

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        cc_done   = 1'b0;
        cc_hit    = 1'b0;
        repeat (3) tick();
        check_eq("reset.outs",
                 {req_ready, rsp_valid, rsp_hit, rsp_err, cc_start, cc_rw, cc_addr, busy, grant_id, state},
                 '0);

        // 1: single read from requester 0, one-cycle engine, hit
        a_tb  = '{32'h0000_1230, 32'h0, 32'h0, 32'h0};
        rw_tb = '{1'b0, 1'b0, 1'b0, 1'b0};
        load_reqs();
        reset_n   = 1'b1;
        req_valid = 4'b0001;
        do_txn("t1", 0, 32'h0000_1230, 1'b0, 1'b1, 1, 1'b0);
        req_valid = 4'b0000;

        // 2: all requesters held valid after a fresh reset -> 0,1,2,3,0
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_tb[i]  = 32'h1000_0000 + 32'(i * 'h40);
            rw_tb[i] = i[0];
        end
        load_reqs();
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++)
            do_txn($sformatf("t2.%0d", n), t2_order[n], a_tb[t2_order[n]], rw_tb[t2_order[n]],
                   n[0], 1, 1'b0);

        // 3: wrap-around scan
        req_valid = 4'b1000;
        do_txn("t3.g3", 3, a_tb[3], rw_tb[3], 1'b0, 2, 1'b0);
        req_valid = 4'b0100;
        do_txn("t3.g2", 2, a_tb[2], rw_tb[2], 1'b1, 1, 1'b0);
        req_valid = 4'b1001;
        do_txn("t3.g3b", 3, a_tb[3], rw_tb[3], 1'b1, 1, 1'b0);
        do_txn("t3.g0", 0, a_tb[0], rw_tb[0], 1'b0, 1, 1'b0);
        req_valid = 4'b0000;

        // 4a: engine never completes -> abort after 255 WAIT cycles
        req_valid = 4'b0010;
        tick();                                   // ISSUE
        check_eq("t4.ready", req_ready, 4'b0010);
        req_valid = 4'b0000;
        cc_hit    = 1'b1;                         // not qualified by done
        bad = 0;
        for (int c = 0; c < 255; c++) begin
            tick();
            if (rsp_valid != 4'b0 || busy != 1'b1 || state != 2'd2) bad++;
        end
        check_eq("t4.no_early_rsp", 64'(bad), 64'd0);
        tick();                                   // RESP
        cc_hit = 1'b0;
        check_eq("t4.rsp_valid", rsp_valid, 4'b0010);
        check_eq("t4.err_hit", {rsp_err, rsp_hit}, 2'b10);
        tick();
        check_eq("t4.idle", {rsp_valid, busy}, 5'b0);

        // 4b: done on the final WAIT cycle beats the timeout
        req_valid = 4'b0100;
        do_txn("t4b", 2, a_tb[2], rw_tb[2], 1'b1, 255, 1'b0);
        req_valid = 4'b0000;

        // 5: reset during WAIT drops the transaction; late done ignored
        req_valid = 4'b0100;
        tick();                                   // ISSUE
        check_eq("t5.ready", req_ready, 4'b0100);
        tick();                                   // WAIT
        req_valid = 4'b0000;
        reset_n   = 1'b0;
        tick();
        check_eq("t5.reset_outs",
                 {req_ready, rsp_valid, rsp_hit, rsp_err, cc_start, cc_rw, cc_addr, busy, grant_id, state},
                 '0);
        reset_n = 1'b1;
        cc_done = 1'b1;
        cc_hit  = 1'b1;
        tick();
        check_eq("t5.done_in_idle", {rsp_valid, busy, state}, 7'b0);
        cc_done = 1'b0;
        cc_hit  = 1'b0;
        tick();
        check_eq("t5.still_idle", {rsp_valid, busy, state}, 7'b0);
        req_valid = 4'b1111;
        do_txn("t5.first", 0, a_tb[0], rw_tb[0], 1'b1, 1, 1'b0);
        req_valid = 4'b0000;

        // 6: write miss, held rw/addr across a 3-cycle lookup, inputs scrambled after grant
        a_tb[1]  = 32'hFFFF_FFF0;
        rw_tb[1] = 1'b1;
        load_reqs();
        req_valid = 4'b0010;
        do_txn("t6", 1, 32'hFFFF_FFF0, 1'b1, 1'b0, 3, 1'b1);
        req_valid = 4'b0000;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
